// File: rtl/spi_slave_rx_tx_if.sv
// Word-level handshake bundle between the SPI slave and its host logic.
// TX words flow in, received words and the overrun flag flow out.
interface spi_slave_rx_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_ready_i;
  logic              rx_overrun_o;

  modport slave (
    input  tx_data_i, tx_valid_i, rx_ready_i,
    output tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o
  );

  modport master (
    output tx_data_i, tx_valid_i, rx_ready_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o
  );
endinterface

// File: rtl/spi_slave_rx_tx.sv
// Mode-0 SPI slave, oversampled by clk_i, with a one-word TX buffer
// and a single registered RX word with a sticky overrun flag.
module spi_slave_rx_tx #(
  parameter int              DATA_W      = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_FILL   = '1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic miso_o,
  output logic miso_oe_o,
  output logic busy_o,
  spi_slave_rx_tx_if.slave bus
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t r_state, w_state_nx;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_vld;
  logic r_sclk_d, r_cs_d, r_armed;
  logic w_sclk, w_cs, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  logic [CW-1:0]     r_cnt;
  logic [DATA_W-2:0] r_rx_sh;
  logic [DATA_W-1:0] r_tx_sh, r_tx_buf, r_rx_data;
  logic              r_tx_full, r_rx_valid, r_ovr;
  logic              w_active, w_start, w_rise, w_fall;
  logic              w_last, w_bnd, w_reload, w_accept;
  logic [DATA_W-1:0] w_rx_word;

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // r_armed blocks a start until cs_n is seen high after reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_vld       <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      if (r_vld[SYNC_STAGES-1] && w_cs)
        r_armed <= 1'b1;
    end
  end

  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = r_armed & ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_cs_fall) w_state_nx = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_o    = 1'b0;
    miso_oe_o = 1'b0;
    miso_o    = 1'b0;
    if (r_state == ACTIVE) begin
      busy_o    = 1'b1;
      miso_oe_o = 1'b1;
      miso_o    = r_tx_sh[DATA_W-1];
    end
  end

  assign w_active  = (r_state == ACTIVE);
  assign w_start   = (r_state == IDLE) & w_cs_fall;
  assign w_rise    = w_active & ~w_cs_rise & w_sclk_rise;
  assign w_fall    = w_active & ~w_cs_rise & w_sclk_fall;
  assign w_last    = (r_cnt == CW'(DATA_W - 1));
  assign w_bnd     = (r_cnt == '0);
  assign w_reload  = w_start | (w_fall & w_bnd);
  assign w_accept  = bus.tx_valid_i & ~r_tx_full;
  assign w_rx_word = {r_rx_sh, w_mosi};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt      <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
      r_tx_buf   <= '0;
      r_tx_full  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_start)
        r_cnt <= '0;
      else if (w_rise)
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;

      if (w_rise)
        r_rx_sh <= w_rx_word[DATA_W-2:0];

      // reload never bypasses a word accepted in the same cycle
      if (w_reload)
        r_tx_sh <= r_tx_full ? r_tx_buf : TX_FILL;
      else if (w_fall)
        r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};

      if (w_accept) begin
        r_tx_buf  <= bus.tx_data_i;
        r_tx_full <= 1'b1;
      end else if (w_reload) begin
        r_tx_full <= 1'b0;
      end

      if (w_rise && w_last) begin
        r_rx_data  <= w_rx_word;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !bus.rx_ready_i)
          r_ovr <= 1'b1;
      end else if (r_rx_valid && bus.rx_ready_i) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign bus.tx_ready_o   = ~r_tx_full;
  assign bus.rx_data_o    = r_rx_data;
  assign bus.rx_valid_o   = r_rx_valid;
  assign bus.rx_overrun_o = r_ovr;
endmodule

// File: doc/spi_slave_rx_tx.md
SPI_SLAVE_RX_TX -- requirements
Module: spi_slave_rx_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per SPI word (legal 4..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sclk_i, cs_n_i and mosi_i (legal 2..3).
REQ-003 SHALL have parameter TX_FILL, default all-ones, the word shifted out when no TX word is buffered.
REQ-004 SHALL have port clk_i  input  1  system clock; all logic on its rising edge; f_clk >= 4*f_sclk.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports sclk_i, cs_n_i, mosi_i  input  1 each  SPI pins from the master (mode 0: CPOL=0, CPHA=0), asynchronous to clk_i.
REQ-007 SHALL have ports miso_o  output  1  serial data to the master; miso_oe_o  output  1  MISO pad drive enable.
REQ-008 SHALL have ports tx_data_i  input  DATA_W  next word to send; tx_valid_i  input  1  word offered; tx_ready_o  output  1  buffer can accept.
REQ-009 SHALL have ports rx_data_o  output  DATA_W  last received word; rx_valid_o  output  1  word available; rx_ready_i  input  1  word consumed.
REQ-010 SHALL have ports rx_overrun_o  output  1  sticky overrun flag; busy_o  output  1  transaction in progress.

Function
REQ-011 SHALL pass sclk_i, cs_n_i, mosi_i through SYNC_STAGES flops each, then detect sclk rising/falling edges and cs_n falling/rising edges against a one-cycle-delayed copy of the synchronized signal.
REQ-012 SHALL implement FSM IDLE, ACTIVE: IDLE->ACTIVE on synchronized cs_n falling edge; ACTIVE->IDLE on synchronized cs_n rising edge; no other transitions.
REQ-013 SHALL drive busy_o=1 and miso_oe_o=1 exactly while in ACTIVE; miso_o SHALL be 0 in IDLE.
REQ-014 SHALL, on IDLE->ACTIVE, load the TX shifter with the buffered word if present (clearing the buffer), else TX_FILL, clear the bit counter, and present the shifter MSB on miso_o in that same cycle.
REQ-015 SHALL, in ACTIVE on each synchronized sclk rising edge, shift synchronized mosi into the RX shifter LSB (MSB-first) and increment the bit counter, which is $clog2(DATA_W) bits wide and wraps from DATA_W-1 to 0.
REQ-016 SHALL, on the rising edge where the counter is DATA_W-1, register the completed word into rx_data_o and set rx_valid_o in the same clk_i cycle as the sample, i.e. SYNC_STAGES+1 clk_i edges after the pin edge.
REQ-017 SHALL hold rx_valid_o and rx_data_o until a cycle with rx_ready_i=1, then clear rx_valid_o on the next edge.
REQ-018 SHALL, if a word completes while rx_valid_o=1 and rx_ready_i=0, overwrite rx_data_o, keep rx_valid_o=1, and set rx_overrun_o=1 until reset.
REQ-019 SHALL, in ACTIVE on each synchronized sclk falling edge, shift the TX shifter left and drive the new MSB on miso_o; when the counter is 0 (word boundary), it SHALL instead reload from the buffer (clearing it) or TX_FILL.
REQ-020 SHALL have a one-entry TX buffer: tx_ready_o = buffer empty; a word is accepted on tx_valid_i & tx_ready_o.
REQ-021 SHALL, on accept and reload in the same cycle with the buffer empty, reload TX_FILL and store the accepted word; there is no bypass.
REQ-022 SHALL, on cs_n rising mid-word, discard the partial RX and TX words without asserting rx_valid_o; the TX buffer contents SHALL be kept.
REQ-023 SHALL ignore sclk edges and mosi while in IDLE.

Reset
REQ-024 SHALL, while rst_ni=0 at a clk_i edge, set state IDLE, counter 0, shifters 0, TX buffer empty, sclk/mosi synchronizers 0, and cs_n synchronizers 1.
REQ-025 SHALL hold outputs during and after reset at: miso_o=0, miso_oe_o=0, busy_o=0, rx_data_o=0, rx_valid_o=0, rx_overrun_o=0, tx_ready_o=1.
REQ-026 SHALL let reset asserted mid-transaction abort it and return to IDLE; a cs_n already low at reset release SHALL NOT start a transaction until cs_n goes high then low.

Verification
REQ-027 Push tx 0xA5, then master sends 0x3C with 8 mode-0 clocks -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o=0x3C with rx_valid_o rising 3 clk_i after the 8th sclk rise.
REQ-028 No TX word buffered, 2-word transfer -> MISO is 0xFF,0xFF; two rx_valid_o assertions; tx_ready_o stays 1.
REQ-029 rx_ready_i=0 across two received words 0x11, 0x22 -> rx_data_o=0x22, rx_valid_o=1, rx_overrun_o=1 until reset.
REQ-030 cs_n raised after 5 sclk edges -> no rx_valid_o, busy_o=0, miso_oe_o=0; the next full word is received correctly.
REQ-031 tx_valid_i asserted in the cycle of the word-boundary reload with the buffer empty -> current word TX_FILL, next word = the offered data.
REQ-032 rst_ni=0 at bit 4 with cs_n held low -> all outputs at reset values; no transaction until a fresh cs_n falling edge.
